seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Time-multiplexed scan driver for the board's 8-digit common-anode 7-segment display.
- Consumes the 64-bit active-low segment vector produced by the nibble-to-segment converter: byte d is digit d, bit7 = dp, bits6:0 = g..a.
- Drives one digit at a time onto shared segment lines. Provides per-frame tear-free latching, a guard blank between digits, and 16-step brightness via duty cycle.
- Sits between the converter and the top-level pins.

Parameters:
- SUB_CYCLES, 6250, clock cycles per brightness subphase; 16 subphases make one digit slot (100 MHz gives 1 ms per digit, 8 ms per frame); minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- seg_data_in  in  64  active-low segment patterns, byte d is digit d
- enable  in  1  1 = scan, 0 = display dark
- bright  in  4  brightness; 0 = dark, 15 = maximum
- seg_out  out  8  active-low segment/dp lines
- an_out  out  8  active-low digit selects; bit d selects digit d
- digit_idx  out  3  digit currently addressed
- frame_start  out  1  one-cycle pulse at the first cycle of each frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: seg_out=8'hFF, an_out=8'hFF, digit_idx=0, frame_start=0, shadow register=64'hFFFF_FFFF_FFFF_FFFF, shadow brightness=0, state=IDLE, all counters 0.
- Counter chain: sub_cnt counts 0..SUB_CYCLES-1. On its wrap, phase counts 0..15. On phase wrap, digit counts 0..7. Digit wraps 7 to 0.
- Frame = 8*16*SUB_CYCLES cycles.
- State IDLE:
  - Counters held at 0; seg_out and an_out are 8'hFF.
  - enable sampled 1 moves to SCAN with counters at 0, and starts a frame.
- State SCAN:
  - Counters run freely.
  - enable sampled 0 moves to IDLE: counters cleared; outputs 8'hFF from the next cycle.
  - Any partial frame is abandoned.
- Frame start (entry to SCAN, or counter wrap from digit 7/phase 15/last sub to 0/0/0):
  - shadow <= seg_data_in and shadow_bright <= bright in the same edge.
  - seg_data_in and bright changes mid-frame have no visible effect until the next frame.
- Outputs are registered and lag the counter state by exactly one cycle. For counter state (d, k):
  - Lit when 1 <= k <= shadow_bright: an_out = ~(8'b1 << d), seg_out = shadow[8d+7:8d].
  - Otherwise: an_out = 8'hFF, seg_out = 8'hFF.
  - Phase 0 is always a guard blank, which prevents ghosting on digit change.
- digit_idx = d, with the same one-cycle lag.
- frame_start = 1 exactly in the cycle whose outputs reflect state (0,0,0) of a frame.
- Duty per digit = shadow_bright/16; at most one an_out bit is low at any time.
- rst during SCAN returns every output to its reset value at the next edge; rst has priority over enable.
- No arithmetic overflow: counters compare against their terminal values; the digit counter is 3 bits and wraps naturally.

Decomposition:
- Shared segment package/header holds:
  - NUM_DIGITS=8
  - PHASES=16
  - SEG_BLANK=8'hFF
  - AN_OFF=8'hFF
  - Segment byte layout: bit7 = dp, active-low.
- One sub-module, seg_scan_timer, holds the sub/phase/digit counter chain. Its outputs are sub_cnt, phase, digit and frame_wrap; its inputs are clk, rst and run.
- The top level holds the IDLE/SCAN FSM, the shadow latch and the output registers.

Test Plan (SUB_CYCLES=2: 32-cycle slot, 256-cycle frame):
- Reset: rst=1 for 3 cycles, enable=1 -> seg_out=FF, an_out=FF, frame_start=0 throughout.
- Basic scan: data=64'h1716151413121110, bright=15, enable rises ->
  - frame_start pulse.
  - 2 cycles an=FF.
  - 30 cycles an=FE, seg=10.
  - Then 2 blank + 30 cycles an=FD, seg=11, and so on through digit 7 (an=7F, seg=17).
  - frame_start again 256 cycles later.
- Brightness: bright=4 latched -> each digit slot is 2 cycles blank, 8 cycles lit, 22 cycles blank. bright=0 -> an=FF for the full frame while frame_start still pulses every 256 cycles.
- Tear-free: change data to 64'h0 while digit 3 is lit -> digits 3-7 still show 13..17 this frame; the next frame shows seg=00 on all digits.
- Enable drop: enable=0 during digit 5 -> next cycle an=FF, seg=FF, digit_idx=0. Re-enable -> frame_start, restart at digit 0 with freshly latched data.
- Mid-scan reset: rst=1 during digit 2 lit -> next cycle all outputs at reset values. With enable held 1, release rst -> new frame starts, frame_start pulses.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 8-digit common-anode scan driver.
// Segment bytes are active-low with bit7 = dp and bits6:0 = g..a.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int PHASES     = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // A counter of width 1 still works when SUB_CYCLES is 1.
  function automatic int sub_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] an_select(input logic [2:0] d);
    return ~(8'b1 << d);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Sub-cycle / brightness-phase / digit counter chain for the scan driver.
// Holds all counters at zero while run is low.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int  SUB_CYCLES = 6250,
  localparam int SUB_W      = sub_width(SUB_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [SUB_W-1:0] sub_cnt,
  output logic [3:0]       phase,
  output logic [2:0]       digit,
  output logic             frame_wrap
);

  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SUB_CYCLES - 1);
  localparam logic [3:0]       PHASE_LAST = 4'(PHASES - 1);
  localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [3:0]       phase_q, phase_d;
  logic [2:0]       digit_q, digit_d;
  logic             sub_last, phase_last, digit_last;

  assign sub_last   = (sub_q == SUB_LAST);
  assign phase_last = (phase_q == PHASE_LAST);
  assign digit_last = (digit_q == DIGIT_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sub_d   = sub_q;
    phase_d = phase_q;
    digit_d = digit_q;
    if (!run) begin
      sub_d   = '0;
      phase_d = '0;
      digit_d = '0;
    end else if (sub_last) begin
      sub_d = '0;
      if (phase_last) begin
        phase_d = '0;
        digit_d = digit_q + 3'd1;
      end else begin
        phase_d = phase_q + 4'd1;
      end
    end else begin
      sub_d = sub_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q   <= '0;
      phase_q <= '0;
      digit_q <= '0;
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
      digit_q <= digit_d;
    end
  end

  assign sub_cnt    = sub_q;
  assign phase      = phase_q;
  assign digit      = digit_q;
  assign frame_wrap = run & sub_last & phase_last & digit_last;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scan driver: per-frame shadow latch,
// guard blank on phase 0 and 16-step duty-cycle brightness.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int  SUB_CYCLES = 6250,
  localparam int SUB_W      = sub_width(SUB_CYCLES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg_data_in,
  input  logic        enable,
  input  logic [3:0]  bright,
  output logic [7:0]  seg_out,
  output logic [7:0]  an_out,
  output logic [2:0]  digit_idx,
  output logic        frame_start
);

  scan_state_e      state_q;
  logic [63:0]      shadow_q;
  logic [3:0]       shadow_bright_q;
  logic [7:0]       seg_q, an_q;
  logic [2:0]       digit_idx_q;
  logic             frame_start_q;

  logic             run, load, lit, at_origin;
  logic [SUB_W-1:0] sub_cnt;
  logic [3:0]       phase;
  logic [2:0]       digit;
  logic             frame_wrap;

  // Counters advance only while staying in SCAN; entry and exit edges leave them at zero.
  assign run  = (state_q == ST_SCAN) && enable;
  assign load = ((state_q == ST_IDLE) && enable) || frame_wrap;

  seg_scan_timer #(.SUB_CYCLES(SUB_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .sub_cnt    (sub_cnt),
    .phase      (phase),
    .digit      (digit),
    .frame_wrap (frame_wrap)
  );

  // Phase 0 is never lit, giving a guard blank at every digit change.
  assign lit       = (phase != 4'd0) && (phase <= shadow_bright_q);
  assign at_origin = (sub_cnt == '0) && (phase == 4'd0) && (digit == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      shadow_q        <= {NUM_DIGITS{SEG_BLANK}};
      shadow_bright_q <= '0;
      seg_q           <= SEG_BLANK;
      an_q            <= AN_OFF;
      digit_idx_q     <= '0;
      frame_start_q   <= 1'b0;
    end else begin
      state_q <= enable ? ST_SCAN : ST_IDLE;

      if (load) begin
        shadow_q        <= seg_data_in;
        shadow_bright_q <= bright;
      end

      if (run) begin
        digit_idx_q   <= digit;
        frame_start_q <= at_origin;
        if (lit) begin
          an_q  <= an_select(digit);
          seg_q <= shadow_q[8*digit +: 8];
        end else begin
          an_q  <= AN_OFF;
          seg_q <= SEG_BLANK;
        end
      end else begin
        digit_idx_q   <= '0;
        frame_start_q <= 1'b0;
        an_q          <= AN_OFF;
        seg_q         <= SEG_BLANK;
      end
    end
  end

  assign seg_out     = seg_q;
  assign an_out      = an_q;
  assign digit_idx   = digit_idx_q;
  assign frame_start = frame_start_q;

endmodule
